// File: rtl/pin_route_pkg.sv
// Shared types and constants for the board pin-routing sequencer.
package pin_route_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DRAIN  = 2'd1,
    SETTLE = 2'd2
  } route_state_t;

  // Group indices, one per routing switch (SW12..SW15)
  localparam int unsigned GRP_PS2   = 0;
  localparam int unsigned GRP_VGA   = 1;
  localparam int unsigned GRP_AUDIO = 2;
  localparam int unsigned GRP_PLUG  = 3;

  localparam int unsigned NUM_GROUPS_DEF    = 4;
  localparam int unsigned GUARD_CYCLES_DEF  = 16;
  localparam int unsigned SETTLE_CYCLES_DEF = 16;
  localparam int unsigned CNT_W             = 8;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for quasi-static asynchronous inputs, reset to 0.
module sync_2ff #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= '0;
      q    <= '0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pin_route_sequencer.sv
// Break-before-make sequencer for run-time pin-route changes: one group at a
// time, lowest index first, with guard and settle windows of forced Z.
module pin_route_sequencer
  import pin_route_pkg::*;
#(
  parameter int unsigned           NUM_GROUPS    = NUM_GROUPS_DEF,
  parameter int unsigned           GUARD_CYCLES  = GUARD_CYCLES_DEF,
  parameter int unsigned           SETTLE_CYCLES = SETTLE_CYCLES_DEF,
  parameter logic [NUM_GROUPS-1:0] RESET_MASK    = NUM_GROUPS'(4'b1000)
) (
  input  logic                  clk_cog,
  input  logic                  nres,
  input  logic [NUM_GROUPS-1:0] sel_req,
  output logic [NUM_GROUPS-1:0] sel_active,
  output logic [NUM_GROUPS-1:0] grp_hiz,
  output logic                  busy,
  output logic                  route_done,
  output logic                  hold_n
);

  localparam int unsigned IDX_W = (NUM_GROUPS > 1) ? $clog2(NUM_GROUPS) : 1;

  logic [NUM_GROUPS-1:0] sel_s;
  logic [NUM_GROUPS-1:0] pending;
  logic [IDX_W-1:0]      low_idx;

  route_state_t          state, state_nxt;
  logic [IDX_W-1:0]      cur, cur_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [NUM_GROUPS-1:0] sel_active_nxt, grp_hiz_nxt;
  logic                  busy_nxt, route_done_nxt, hold_n_nxt;

  sync_2ff #(.WIDTH(NUM_GROUPS)) u_sync (
    .clk   (clk_cog),
    .rst_n (nres),
    .d     (sel_req),
    .q     (sel_s)
  );

  assign pending = sel_s ^ sel_active;

  // Lowest-index pending group wins
  always_comb begin
    low_idx = '0;
    for (int g = NUM_GROUPS - 1; g >= 0; g--) begin
      if (pending[g]) low_idx = IDX_W'(g);
    end
  end

  always_ff @(posedge clk_cog or negedge nres) begin
    if (!nres) begin
      state      <= IDLE;
      cur        <= '0;
      cnt        <= '0;
      sel_active <= '0;
      grp_hiz    <= '0;
      busy       <= 1'b0;
      route_done <= 1'b0;
      hold_n     <= 1'b1;
    end else begin
      state      <= state_nxt;
      cur        <= cur_nxt;
      cnt        <= cnt_nxt;
      sel_active <= sel_active_nxt;
      grp_hiz    <= grp_hiz_nxt;
      busy       <= busy_nxt;
      route_done <= route_done_nxt;
      hold_n     <= hold_n_nxt;
    end
  end

  always_comb begin
    state_nxt      = state;
    cur_nxt        = cur;
    cnt_nxt        = cnt;
    sel_active_nxt = sel_active;
    grp_hiz_nxt    = grp_hiz;
    hold_n_nxt     = hold_n;
    route_done_nxt = 1'b0;

    case (state)
      IDLE: begin
        if (|pending) begin
          state_nxt   = DRAIN;
          cur_nxt     = low_idx;
          grp_hiz_nxt = NUM_GROUPS'(1) << low_idx;
          hold_n_nxt  = ~RESET_MASK[low_idx];
          cnt_nxt     = CNT_W'(GUARD_CYCLES - 1);
        end
      end
      DRAIN: begin
        // A reverted request abandons the change before the select moves
        if (!pending[cur]) begin
          state_nxt   = IDLE;
          grp_hiz_nxt = '0;
          hold_n_nxt  = 1'b1;
        end else if (cnt == '0) begin
          sel_active_nxt[cur] = sel_s[cur];
          state_nxt           = SETTLE;
          cnt_nxt             = CNT_W'(SETTLE_CYCLES - 1);
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      SETTLE: begin
        if (cnt == '0) begin
          state_nxt      = IDLE;
          grp_hiz_nxt    = '0;
          hold_n_nxt     = 1'b1;
          route_done_nxt = 1'b1;
        end else begin
          cnt_nxt = cnt - CNT_W'(1);
        end
      end
      default: begin
        state_nxt   = IDLE;
        grp_hiz_nxt = '0;
        hold_n_nxt  = 1'b1;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

endmodule

// File: tb/tb_pin_route_sequencer.sv
// Directed bench for pin_route_sequencer with GUARD=4, SETTLE=3.
module tb_pin_route_sequencer;

  localparam int unsigned GUARD  = 4;
  localparam int unsigned SETTLE = 3;

  logic       clk_cog;
  logic       nres;
  logic [3:0] sel_req;
  logic [3:0] sel_active;
  logic [3:0] grp_hiz;
  logic       busy;
  logic       route_done;
  logic       hold_n;

  int n_pass;
  int n_total;

  typedef struct {
    logic [3:0]  req;
    logic [10:0] exp;
  } vec_t;

  vec_t vecs[$];

  pin_route_sequencer #(
    .NUM_GROUPS    (4),
    .GUARD_CYCLES  (GUARD),
    .SETTLE_CYCLES (SETTLE),
    .RESET_MASK    (4'b1000)
  ) dut (
    .clk_cog    (clk_cog),
    .nres       (nres),
    .sel_req    (sel_req),
    .sel_active (sel_active),
    .grp_hiz    (grp_hiz),
    .busy       (busy),
    .route_done (route_done),
    .hold_n     (hold_n)
  );

  initial clk_cog = 1'b0;
  always #5 clk_cog = ~clk_cog;

  function automatic logic [10:0] outs();
    return {sel_active, grp_hiz, busy, route_done, hold_n};
  endfunction

  function automatic logic [10:0] mk(input logic [3:0] act, input logic [3:0] hiz,
                                     input logic bsy, input logic rd, input logic hn);
    return {act, hiz, bsy, rd, hn};
  endfunction

  task automatic step();
    @(posedge clk_cog);
    #1;
  endtask

  task automatic check(input string name, input logic [10:0] act, input logic [10:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got act/hiz/busy/done/hold_n=%b want %b", name, act, exp);
  endtask

  task automatic push(input logic [3:0] req, input logic [10:0] exp);
    vec_t v;
    v.req = req;
    v.exp = exp;
    vecs.push_back(v);
  endtask

  logic [3:0] prev_act;
  int         hiz_cnt[4];
  int         waited;

  initial begin
    n_pass  = 0;
    n_total = 0;
    nres    = 1'b0;
    sel_req = 4'b0000;

    // Vector table: idle after reset, single group 1, then groups 0 and 3
    for (int j = 0; j < 3; j++) push(4'b0000, mk(4'b0000, 4'b0000, 0, 0, 1));
    for (int j = 0; j <= 10; j++) begin
      logic on;
      on = (j >= 2 && j <= 8);
      push(4'b0010, mk((j >= 6) ? 4'b0010 : 4'b0000, on ? 4'b0010 : 4'b0000,
                       on, (j == 9), 1'b1));
    end
    for (int j = 0; j <= 18; j++) begin
      logic [3:0] a;
      logic [3:0] h;
      a = (j < 6) ? 4'b0010 : (j < 14) ? 4'b0011 : 4'b1011;
      h = (j >= 2 && j <= 8) ? 4'b0001 : (j >= 10 && j <= 16) ? 4'b1000 : 4'b0000;
      push(4'b1011, mk(a, h, (h != 4'b0000), (j == 9 || j == 17), !(j >= 10 && j <= 16)));
    end

    repeat (2) step();
    check("in_reset", outs(), mk(4'b0000, 4'b0000, 0, 0, 1));
    nres = 1'b1;

    foreach (vecs[i]) begin
      sel_req = vecs[i].req;
      step();
      check($sformatf("vec%0d", i), outs(), vecs[i].exp);
    end

    // Revert group 2 during DRAIN: abort with no flip and no done pulse
    sel_req = 4'b1111;
    step(); step();
    step(); check("abort_e2", outs(), mk(4'b1011, 4'b0100, 1, 0, 1));
    sel_req = 4'b1011;
    step(); check("abort_e3", outs(), mk(4'b1011, 4'b0100, 1, 0, 1));
    step(); check("abort_e4", outs(), mk(4'b1011, 4'b0100, 1, 0, 1));
    step(); check("abort_e5", outs(), mk(4'b1011, 4'b0000, 0, 0, 1));
    step(); check("abort_e6", outs(), mk(4'b1011, 4'b0000, 0, 0, 1));
    step(); check("abort_e7", outs(), mk(4'b1011, 4'b0000, 0, 0, 1));

    // Toggle group 1 back during SETTLE: finish, then re-sequence
    sel_req = 4'b1001;
    repeat (3) step();
    check("tog_e2", outs(), mk(4'b1011, 4'b0010, 1, 0, 1));
    repeat (4) step();
    check("tog_e6", outs(), mk(4'b1001, 4'b0010, 1, 0, 1));
    sel_req = 4'b1011;
    step(); check("tog_e7", outs(), mk(4'b1001, 4'b0010, 1, 0, 1));
    step(); check("tog_e8", outs(), mk(4'b1001, 4'b0010, 1, 0, 1));
    step(); check("tog_e9", outs(), mk(4'b1001, 4'b0000, 0, 1, 1));
    step(); check("tog_e10", outs(), mk(4'b1001, 4'b0010, 1, 0, 1));
    repeat (3) step();
    check("tog_e13", outs(), mk(4'b1001, 4'b0010, 1, 0, 1));
    step(); check("tog_e14", outs(), mk(4'b1011, 4'b0010, 1, 0, 1));
    repeat (3) step();
    check("tog_e17", outs(), mk(4'b1011, 4'b0000, 0, 1, 1));
    step(); check("tog_e18", outs(), mk(4'b1011, 4'b0000, 0, 0, 1));

    // Asynchronous reset in SETTLE of the plug group, then recovery
    sel_req = 4'b0011;
    repeat (8) step();
    check("rst_pre", outs(), mk(4'b0011, 4'b1000, 1, 0, 0));
    #3 nres = 1'b0;
    #1 check("rst_async", outs(), mk(4'b0000, 4'b0000, 0, 0, 1));
    #1 nres = 1'b1;
    waited = 0;
    do begin
      step();
      waited++;
    end while (!(sel_active == 4'b0011 && !busy) && waited < 60);
    check("rst_recover", outs(), mk(4'b0011, 4'b0000, 0, waited > 0 ? route_done : 1'b0, 1));

    // Random stress: one-hot hiz, hold_n tracks plug group, guarded flips
    prev_act = sel_active;
    for (int g = 0; g < 4; g++) hiz_cnt[g] = 0;
    for (int c = 0; c < 10000; c++) begin
      if ($urandom_range(7) == 0) sel_req = 4'($urandom);
      step();
      n_total++;
      if ($onehot0(grp_hiz) && (hold_n == !grp_hiz[3])) n_pass++;
      else $display("FAIL rand_onehot cycle %0d: hiz=%b hold_n=%b", c, grp_hiz, hold_n);
      for (int g = 0; g < 4; g++) begin
        if (sel_active[g] != prev_act[g]) begin
          n_total++;
          if (grp_hiz[g] && hiz_cnt[g] >= int'(GUARD)) n_pass++;
          else $display("FAIL rand_flip g%0d cycle %0d: hiz=%b held=%0d need %0d",
                        g, c, grp_hiz, hiz_cnt[g], GUARD);
        end
        hiz_cnt[g] = grp_hiz[g] ? hiz_cnt[g] + 1 : 0;
      end
      prev_act = sel_active;
    end

    waited = 0;
    do begin
      step();
      waited++;
    end while ((busy || sel_active != sel_req) && waited < 200);
    check("rand_final", {sel_active, grp_hiz, busy, 2'b01}, {sel_req, 4'b0000, 1'b0, 2'b01});

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pin_route_sequencer.md
Name: pin_route_sequencer

Overview:
- Sequences run-time changes of board pin-routing selects (debounced SW12–SW15) into the clk_cog domain.
- Applies break-before-make to every change: both alternatives of the affected routing group are forced to Z before the mux select flips, and held at Z while the new route settles.
- Serialises simultaneous requests, one group at a time, lowest index first.
- Optionally holds the core in reset while the serial-port/Prop-plug group is rerouted.
- Sits between the switch debouncer and the top-level pin multiplexers.

Parameters:
- NUM_GROUPS, 4, number of independent routing groups (bit g of every group-wide vector).
- GUARD_CYCLES, 16, cycles of forced Z before the select flips; legal range 1..255.
- SETTLE_CYCLES, 16, cycles of forced Z after the flip; legal range 1..255.
- RESET_MASK, 4'b1000, groups whose rerouting also asserts hold_n.

Ports:
- clk_cog  in  1  block clock.
- nres  in  1  asynchronous active-low reset.
- sel_req  in  NUM_GROUPS  requested route per group; asynchronous to clk_cog (debounced switches).
- sel_active  out  NUM_GROUPS  route select driven into the pin muxes.
- grp_hiz  out  NUM_GROUPS  1 = force both alternatives of group g to Z and hold its pin_in_ext bits at 0.
- busy  out  1  FSM not in IDLE.
- route_done  out  1  one-cycle pulse when a select flip has completed settling.
- hold_n  out  1  0 = request core reset (ANDed into nres generation at top level).

Behaviour:
- Reset is asynchronous and active-low: nres low forces all state immediately, regardless of clk_cog.
- Reset values: sel_active=0, grp_hiz=0, busy=0, route_done=0, hold_n=1, synchroniser=0, FSM=IDLE, counter=0. All outputs are registered.
- Synchroniser: sel_req passes through a 2-flop synchroniser per bit; the stage-2 output is sel_s.
  - Latency: sel_req changes before edge E0; sel_s changes at E1.
- pending[g] = sel_s[g] != sel_active[g].
- States: IDLE, DRAIN, SETTLE. The current group index cur is a register.
- IDLE:
  - If any pending bit is set, cur <= lowest set index, state <= DRAIN, grp_hiz[cur] <= 1, counter <= GUARD_CYCLES-1.
  - If RESET_MASK[cur], hold_n <= 0 on the same edge.
  - Otherwise remain in IDLE.
  - First grp_hiz assertion occurs at E2 relative to the sel_req change.
- DRAIN:
  - Counter decrements each cycle.
  - If pending[cur] clears (request reverted), abort: state <= IDLE, grp_hiz[cur] <= 0, hold_n <= 1, sel_active unchanged, no route_done.
  - Otherwise, when counter==0: sel_active[cur] <= sel_s[cur], state <= SETTLE, counter <= SETTLE_CYCLES-1.
  - Net effect: sel_active flips exactly GUARD_CYCLES cycles after grp_hiz rises.
- SETTLE:
  - Counter decrements each cycle; sel_s changes are ignored.
  - When counter==0: state <= IDLE, grp_hiz[cur] <= 0, hold_n <= 1, route_done <= 1 for one cycle.
  - A further change of the same group is handled as a new event from IDLE.
- Timing: grp_hiz[cur] is high for exactly GUARD_CYCLES+SETTLE_CYCLES cycles. At most one grp_hiz bit is high at any time.
- Back-to-back requests: the next pending group enters DRAIN on the edge after the IDLE cycle. One idle cycle between groups is mandatory and is also when grp_hiz is low.
- Simultaneous changes are served in ascending index order. No starvation, since a served group stops pending.
- busy = (state != IDLE), registered alongside the state.
- Reset mid-operation: outputs return immediately to reset values. A select that had already flipped reverts to 0, and a mismatch is re-sequenced after release.
- Counter width: 8 bits.

Decomposition:
- Package pin_route_pkg:
  - route_state_t enum {IDLE, DRAIN, SETTLE}.
  - Group index constants GRP_PS2=0 (SW12), GRP_VGA=1 (SW13), GRP_AUDIO=2 (SW14), GRP_PLUG=3 (SW15).
  - Default GUARD/SETTLE localparams.
- Sub-module sync_2ff: parameterised width, async active-low reset to 0. Reusable for other switch crossings.

Test Plan:
- Reset release with sel_req=0000 → sel_active=0000, busy=0, grp_hiz=0000 indefinitely. Assert nres low mid-SETTLE → all outputs reset in the same cycle without a clock edge.
- GUARD=4, SETTLE=3; sel_req 0000→0010 → grp_hiz[1] rises at E2 and stays high 7 cycles. sel_active[1] flips 4 cycles after grp_hiz[1] rises. route_done pulses once as grp_hiz falls. hold_n stays 1.
- sel_req 0000→1001 in one cycle → group 0 sequenced first, one idle cycle with grp_hiz=0000, then group 3. hold_n=0 only during group 3's 7 hiz cycles. Final sel_active=1001.
- During DRAIN of group 2, revert sel_req[2] → grp_hiz[2] drops, no route_done, sel_active unchanged, busy=0.
- During SETTLE of group 1, toggle sel_req[1] back → current sequence completes with sel_active[1]=1 and route_done. A second full sequence then restores sel_active[1]=0.
- Randomized sel_req over 10k cycles → grp_hiz is one-hot or zero at all times. Any sel_active bit changes only while its grp_hiz bit has been high ≥ GUARD cycles.
